// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32 integer core.
// Walks FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes plus a shared memory handshake.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [4:0] op_i,
  input  logic       br_cond_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] wb_src_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] wb_src;
    logic       retire;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  ctrl_t      ctrl;
  logic       illegal;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_I, OP_STORE, OP_R, OP_LUI,
      OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
      default:                    is_legal = 1'b0;
    endcase
  endfunction

  // {alu_src, alu_op}; LUI relies on the datapath forcing rs1 to x0 with an add.
  function automatic logic [2:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_R:      alu_sel = 3'b0_10;
      OP_I:      alu_sel = 3'b1_11;
      OP_BRANCH: alu_sel = 3'b0_01;
      default:   alu_sel = 3'b1_00;
    endcase
  endfunction

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    op_d    = op_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req  = run_i;
        ctrl.ir_write = run_i & mem_ready_i;
        if (run_i && mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = op_i;
        state_d = is_legal(op_i) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        {ctrl.alu_src, ctrl.alu_op} = alu_sel(op_q);
        if (op_q == OP_BRANCH) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = br_cond_i ? 2'b01 : 2'b00;
          ctrl.retire   = 1'b1;
          state_d       = S_FETCH;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Address operands held so the request stays stable across wait cycles.
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (op_q == OP_STORE);
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = 2'b00;
        if (mem_ready_i) begin
          if (op_q == OP_STORE) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 2'b00;
            ctrl.retire   = 1'b1;
            state_d       = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        {ctrl.alu_src, ctrl.alu_op} = alu_sel(op_q);
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.retire    = 1'b1;
        case (op_q)
          OP_LOAD:         ctrl.wb_src = 2'b01;
          OP_JAL, OP_JALR: ctrl.wb_src = 2'b10;
          default:         ctrl.wb_src = 2'b00;
        endcase
        case (op_q)
          OP_JAL:  ctrl.pc_src = 2'b01;
          OP_JALR: ctrl.pc_src = 2'b10;
          default: ctrl.pc_src = 2'b00;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Reset masks every output so an in-flight memory request drops immediately.
  always_comb begin
    mem_req_o   = ~rst_i & ctrl.mem_req;
    mem_we_o    = ~rst_i & ctrl.mem_we;
    ir_write_o  = ~rst_i & ctrl.ir_write;
    pc_write_o  = ~rst_i & ctrl.pc_write;
    pc_src_o    = rst_i ? 2'b00 : ctrl.pc_src;
    reg_write_o = ~rst_i & ctrl.reg_write;
    alu_src_o   = ~rst_i & ctrl.alu_src;
    alu_op_o    = rst_i ? 2'b00 : ctrl.alu_op;
    wb_src_o    = rst_i ? 2'b00 : ctrl.wb_src;
    retire_o    = ~rst_i & ctrl.retire;
    illegal_o   = ~rst_i & illegal;
    state_o     = rst_i ? 3'd0 : state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle stimulus and expected output vectors are queued
// together, then each scenario pops and compares them cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [4:0] op = '0;
  logic       br_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, alu_src, retire, illegal;
  logic [1:0] pc_src, alu_op, wb_src;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] R = 5'b01100, I = 5'b00100, LD = 5'b00000, ST = 5'b01000;
  localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001, LUI = 5'b01101;
  localparam logic [4:0] BAD = 5'b11111;

  typedef struct packed {
    logic       rst;
    logic       run;
    logic       mr;
    logic       bc;
    logic [4:0] op;
  } stim_t;

  stim_t       stim_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] obs;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .op_i(op), .br_cond_i(br_cond),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .reg_write_o(reg_write), .alu_src_o(alu_src), .alu_op_o(alu_op),
    .wb_src_o(wb_src), .retire_o(retire), .illegal_o(illegal), .state_o(state)
  );

  always #5 clk = ~clk;

  // Vector layout: {state, illegal, retire, wb_src, alu_op, alu_src, reg_write, pc_src,
  //                 pc_write, ir_write, mem_we, mem_req}
  function automatic logic [16:0] ev(input logic [2:0] st, input logic mreq, input logic mwe,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic as, input logic [1:0] aop,
                                     input logic [1:0] wbs, input logic ret, input logic ill);
    return {st, ill, ret, wbs, aop, as, rw, pcs, pcw, irw, mwe, mreq};
  endfunction

  function automatic logic [16:0] fetch_v();
    return ev(3'd0, 1, 0, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [16:0] st_only(input logic [2:0] st);
    return ev(st, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  task automatic push(input logic r, input logic rn, input logic mr, input logic bc,
                      input logic [4:0] o, input logic [16:0] e);
    stim_q.push_back('{rst: r, run: rn, mr: mr, bc: bc, op: o});
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus between edges, then sample the combinational outputs.
  task automatic step();
    stim_t s;
    s = stim_q.pop_front();
    @(negedge clk);
    rst = s.rst; run = s.run; mem_ready = s.mr; br_cond = s.bc; op = s.op;
    #1;
    obs = {state, illegal, retire, wb_src, alu_op, alu_src, reg_write, pc_src,
           pc_write, ir_write, mem_we, mem_req};
  endtask

  task automatic test_reset();
    logic [16:0] e;
    push(1, 1, 1, 0, R, st_only(3'd0));
    push(1, 1, 1, 0, R, st_only(3'd0));
    push(0, 0, 1, 0, R, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_rtype();
    logic [16:0] e;
    push(0, 1, 1, 0, R, fetch_v());
    push(0, 1, 1, 0, R, st_only(3'd1));
    // op changes after DECODE must not affect EXEC/WB
    push(0, 1, 1, 0, BAD, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0));
    push(0, 1, 1, 0, BAD, ev(3'd4, 0, 0, 0, 1, 2'b00, 1, 0, 2'b10, 2'b00, 1, 0));
    push(0, 0, 1, 0, BAD, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rtype cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] e;
    logic [16:0] mem_v;
    mem_v = ev(3'd3, 1, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0);
    push(0, 1, 1, 0, LD, fetch_v());
    push(0, 1, 0, 0, LD, st_only(3'd1));
    push(0, 1, 1, 0, LD, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 0, 0, 0, LD, mem_v);
    push(0, 0, 0, 0, LD, mem_v);
    push(0, 0, 1, 0, LD, mem_v);
    push(0, 0, 1, 0, LD, ev(3'd4, 0, 0, 0, 1, 2'b00, 1, 1, 2'b00, 2'b01, 1, 0));
    // mem_ready without a request is ignored
    push(0, 0, 1, 0, LD, st_only(3'd0));
    push(0, 0, 1, 0, LD, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_wait cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    push(0, 1, 1, 0, ST, fetch_v());
    push(0, 1, 1, 0, ST, st_only(3'd1));
    push(0, 1, 1, 0, ST, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 1, 1, 0, ST, ev(3'd3, 1, 1, 0, 1, 2'b00, 0, 1, 2'b00, 2'b00, 1, 0));
    push(0, 1, 1, 1, BR, fetch_v());
    push(0, 1, 1, 1, BR, st_only(3'd1));
    push(0, 1, 1, 1, BR, ev(3'd2, 0, 0, 0, 1, 2'b01, 0, 0, 2'b01, 2'b00, 1, 0));
    push(0, 1, 1, 0, BR, fetch_v());
    push(0, 1, 1, 0, BR, st_only(3'd1));
    push(0, 1, 1, 0, BR, ev(3'd2, 0, 0, 0, 1, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0));
    push(0, 0, 1, 0, BR, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_jumps_itype();
    logic [16:0] e;
    // JALR with one FETCH wait cycle
    push(0, 1, 0, 0, JALR, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    push(0, 1, 1, 0, JALR, fetch_v());
    push(0, 1, 1, 0, JALR, st_only(3'd1));
    push(0, 1, 1, 0, JALR, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 1, 1, 0, JALR, ev(3'd4, 0, 0, 0, 1, 2'b10, 1, 1, 2'b00, 2'b10, 1, 0));
    // JAL with run dropped mid-instruction
    push(0, 1, 1, 0, JAL, fetch_v());
    push(0, 0, 1, 0, JAL, st_only(3'd1));
    push(0, 0, 1, 0, JAL, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 0, 1, 0, JAL, ev(3'd4, 0, 0, 0, 1, 2'b01, 1, 1, 2'b00, 2'b10, 1, 0));
    push(0, 1, 1, 0, I, fetch_v());
    push(0, 1, 1, 0, I, st_only(3'd1));
    push(0, 1, 1, 0, I, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0));
    push(0, 1, 1, 0, I, ev(3'd4, 0, 0, 0, 1, 2'b00, 1, 1, 2'b11, 2'b00, 1, 0));
    push(0, 1, 1, 0, LUI, fetch_v());
    push(0, 1, 1, 0, LUI, st_only(3'd1));
    push(0, 1, 1, 0, LUI, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 1, 1, 0, LUI, ev(3'd4, 0, 0, 0, 1, 2'b00, 1, 1, 2'b00, 2'b00, 1, 0));
    push(0, 0, 1, 0, LUI, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL jumps_itype cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e;
    push(0, 1, 1, 0, BAD, fetch_v());
    push(0, 1, 1, 0, BAD, st_only(3'd1));
    for (int k = 0; k < 11; k++)
      push(0, 1, 1, 0, R, ev(3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1));
    push(1, 1, 1, 0, R, st_only(3'd0));
    push(0, 0, 1, 0, R, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [16:0] e;
    logic [16:0] mem_v;
    mem_v = ev(3'd3, 1, 1, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0);
    push(0, 1, 1, 0, ST, fetch_v());
    push(0, 1, 1, 0, ST, st_only(3'd1));
    push(0, 1, 1, 0, ST, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 1, 0, 0, ST, mem_v);
    // reset lands on the second wait cycle, with memory completing in the same cycle
    push(1, 1, 1, 0, ST, st_only(3'd0));
    push(0, 0, 1, 0, ST, st_only(3'd0));
    push(0, 0, 1, 0, ST, st_only(3'd0));
    // a LOAD right after confirms op_q and the FSM came out clean
    push(0, 1, 1, 0, LD, fetch_v());
    push(0, 1, 1, 0, LD, st_only(3'd1));
    push(0, 1, 1, 0, LD, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 1, 1, 0, LD, ev(3'd3, 1, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    push(0, 0, 1, 0, LD, ev(3'd4, 0, 0, 0, 1, 2'b00, 1, 1, 2'b00, 2'b01, 1, 0));
    push(0, 0, 1, 0, LD, st_only(3'd0));
    for (int n = 1; exp_q.size() != 0; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_mem cyc%0d: got %05h expected %05h", n, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_back_to_back();
    test_jumps_itype();
    test_illegal();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
